// File: rtl/bram_dual_client_arbiter_if.sv
// Client request/grant/read-return signals and the block RAM port signals shared
// between the two clients, the arbiter and the RAM instance.
interface bram_dual_client_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 2
);
    logic              c0_req,    c1_req;
    logic              c0_we,     c1_we;
    logic [ADDR_W-1:0] c0_addr,   c1_addr;
    logic [DATA_W-1:0] c0_wdata,  c1_wdata;
    logic              c0_gnt,    c1_gnt;
    logic              c0_rvalid, c1_rvalid;
    logic [DATA_W-1:0] c0_rdata,  c1_rdata;

    logic              ram_w_en,   ram_r_en;
    logic [ADDR_W-1:0] ram_w_addr, ram_r_addr;
    logic [DATA_W-1:0] ram_w_data;
    logic [DATA_W-1:0] ram_r_data;

    // Arbiter side
    modport slave (
        input  c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
        input  ram_r_data,
        output c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
        output ram_w_en, ram_r_en, ram_w_addr, ram_r_addr, ram_w_data
    );

    // Clients plus RAM side
    modport master (
        output c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
        output ram_r_data,
        input  c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
        input  ram_w_en, ram_r_en, ram_w_addr, ram_r_addr, ram_w_data
    );
endinterface

// File: rtl/bram_dual_client_arbiter.sv
// Round-robin sharing of a simple dual-port RAM (one write, one registered read
// port) between two clients, with read data routed back to the issuing client.
module bram_dual_client_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    bram_dual_client_arbiter_if.slave    bus
);
    logic              w0, w1, r0, r1;
    logic              wg0, wg1, rs0, rs1, rg0, rg1;
    logic              hazard;
    logic              wptr, rptr;
    logic              vld_p1, tag_p1;
    logic [ADDR_W-1:0] w_addr_p0, r_addr_p0;
    logic [DATA_W-1:0] w_data_p0;

    // Stage p0: combinational arbitration and RAM port steering
    always_comb begin
        w0 = bus.c0_req &  bus.c0_we;
        w1 = bus.c1_req &  bus.c1_we;
        r0 = bus.c0_req & ~bus.c0_we;
        r1 = bus.c1_req & ~bus.c1_we;

        wg0 = ~rst & w0 & (~w1 | ~wptr);
        wg1 = ~rst & w1 & (~w0 |  wptr);

        w_addr_p0 = '0;
        w_data_p0 = '0;
        if (wg0) begin
            w_addr_p0 = bus.c0_addr;
            w_data_p0 = bus.c0_wdata;
        end else if (wg1) begin
            w_addr_p0 = bus.c1_addr;
            w_data_p0 = bus.c1_wdata;
        end

        rs0 = ~rst & r0 & (~r1 | ~rptr);
        rs1 = ~rst & r1 & (~r0 |  rptr);

        // A read colliding with this cycle's write waits one cycle so it sees the new data
        hazard = (wg0 | wg1) & (rs0 | rs1)
               & ((rs1 ? bus.c1_addr : bus.c0_addr) == w_addr_p0);
        rg0 = rs0 & ~hazard;
        rg1 = rs1 & ~hazard;

        r_addr_p0 = '0;
        if (rg0)      r_addr_p0 = bus.c0_addr;
        else if (rg1) r_addr_p0 = bus.c1_addr;
    end

    assign bus.c0_gnt     = wg0 | rg0;
    assign bus.c1_gnt     = wg1 | rg1;
    assign bus.ram_w_en   = wg0 | wg1;
    assign bus.ram_w_addr = w_addr_p0;
    assign bus.ram_w_data = w_data_p0;
    assign bus.ram_r_en   = rg0 | rg1;
    assign bus.ram_r_addr = r_addr_p0;

    // Stage p1: pointers update on contention only; tag follows the read into the RAM
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            vld_p1 <= 1'b0;
            tag_p1 <= 1'b0;
        end else begin
            if (w0 & w1)              wptr <= ~wptr;
            if (r0 & r1 & (rg0 | rg1)) rptr <= ~rptr;
            vld_p1 <= rg0 | rg1;
            if (rg0 | rg1)            tag_p1 <= rg1;
        end
    end

    assign bus.c0_rvalid = ~rst & vld_p1 & ~tag_p1;
    assign bus.c1_rvalid = ~rst & vld_p1 &  tag_p1;
    assign bus.c0_rdata  = bus.ram_r_data;
    assign bus.c1_rdata  = bus.ram_r_data;
endmodule

// File: tb/tb_bram_dual_client_arbiter.sv
// Directed bench for bram_dual_client_arbiter with a behavioural 16x2 RAM
// holding a fixed init table.
module tb_bram_dual_client_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic preload;
    int   n_checks = 0;
    int   n_errors = 0;

    bram_dual_client_arbiter_if #(.ADDR_W(4), .DATA_W(2)) bus ();

    bram_dual_client_arbiter #(.ADDR_W(4), .DATA_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] init_val(input int a);
        case (a)
            0: return 2'd0;  1: return 2'd1;  2: return 2'd2;  3: return 2'd3;
            4: return 2'd0;  5: return 2'd1;  6: return 2'd2;  7: return 2'd0;
            8: return 2'd3;  9: return 2'd2; 10: return 2'd1; 11: return 2'd0;
           12: return 2'd3; 13: return 2'd2; 14: return 2'd1; default: return 2'd0;
        endcase
    endfunction

    // RAM with registered read, write-first not needed since hazards are arbitrated away
    logic [1:0] mem [16];
    always_ff @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
        end else if (bus.ram_w_en) begin
            mem[bus.ram_w_addr] <= bus.ram_w_data;
        end
        if (bus.ram_r_en) bus.ram_r_data <= mem[bus.ram_r_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_c0(input logic req, input logic we, input logic [3:0] addr,
                            input logic [1:0] wdata);
        bus.c0_req = req; bus.c0_we = we; bus.c0_addr = addr; bus.c0_wdata = wdata;
    endtask

    task automatic drive_c1(input logic req, input logic we, input logic [3:0] addr,
                            input logic [1:0] wdata);
        bus.c1_req = req; bus.c1_we = we; bus.c1_addr = addr; bus.c1_wdata = wdata;
    endtask

    initial begin
        rst = 1'b1;
        preload = 1'b1;
        drive_c0(1'b0, 1'b0, 4'd0, 2'd0);
        drive_c1(1'b0, 1'b0, 4'd0, 2'd0);
        step();
        step();
        check("reset_c0_rvalid", 32'(bus.c0_rvalid), 0);
        check("reset_c1_rvalid", 32'(bus.c1_rvalid), 0);
        rst = 1'b0;
        preload = 1'b0;

        // Scan: c1 reads every address back-to-back, c0 idle
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) drive_c1(1'b1, 1'b0, 4'(i), 2'd0);
            else        drive_c1(1'b0, 1'b0, 4'd0, 2'd0);
            @(negedge clk);
            if (i < 16) check("scan_gnt", 32'(bus.c1_gnt), 1);
            if (i == 0) check("scan_first_rvalid", 32'(bus.c1_rvalid), 0);
            if (i > 0) begin
                check("scan_rvalid", 32'(bus.c1_rvalid), 1);
                check("scan_rdata", 32'(bus.c1_rdata), 32'(init_val(i - 1)));
                check("scan_c0_rvalid", 32'(bus.c0_rvalid), 0);
            end
            step();
        end
        check("scan_rptr", 32'(dut.rptr), 0);

        // Reset pulse with both clients requesting writes to addr 12
        drive_c0(1'b1, 1'b1, 4'd12, 2'd1);
        drive_c1(1'b1, 1'b1, 4'd12, 2'd2);
        rst = 1'b1;
        @(negedge clk);
        check("rst_c0_gnt", 32'(bus.c0_gnt), 0);
        check("rst_c1_gnt", 32'(bus.c1_gnt), 0);
        check("rst_w_en", 32'(bus.ram_w_en), 0);
        check("rst_r_en", 32'(bus.ram_r_en), 0);
        step();
        rst = 1'b0;

        // Write contention alternates starting with c0
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("wc_c0_gnt", 32'(bus.c0_gnt), 32'(k % 2 == 0));
            check("wc_c1_gnt", 32'(bus.c1_gnt), 32'(k % 2 == 1));
            check("wc_w_data", 32'(bus.ram_w_data), (k % 2 == 0) ? 1 : 2);
            check("wc_r_en", 32'(bus.ram_r_en), 0);
            step();
        end
        drive_c1(1'b0, 1'b0, 4'd0, 2'd0);
        drive_c0(1'b1, 1'b0, 4'd12, 2'd0);
        @(negedge clk);
        check("wc_read_gnt", 32'(bus.c0_gnt), 1);
        step();
        drive_c0(1'b0, 1'b0, 4'd0, 2'd0);
        @(negedge clk);
        check("wc_read_rvalid", 32'(bus.c0_rvalid), 1);
        check("wc_read_rdata", 32'(bus.c0_rdata), 2);
        check("wc_read_c1_rvalid", 32'(bus.c1_rvalid), 0);
        step();

        // Concurrent write (c0) and read (c1) to different addresses
        drive_c0(1'b1, 1'b1, 4'd3, 2'd3);
        drive_c1(1'b1, 1'b0, 4'd5, 2'd0);
        @(negedge clk);
        check("cc_c0_gnt", 32'(bus.c0_gnt), 1);
        check("cc_c1_gnt", 32'(bus.c1_gnt), 1);
        check("cc_w_addr", 32'(bus.ram_w_addr), 3);
        check("cc_r_addr", 32'(bus.ram_r_addr), 5);
        step();
        drive_c0(1'b0, 1'b0, 4'd0, 2'd0);
        drive_c1(1'b0, 1'b0, 4'd0, 2'd0);
        @(negedge clk);
        check("cc_c1_rvalid", 32'(bus.c1_rvalid), 1);
        check("cc_c1_rdata", 32'(bus.c1_rdata), 1);
        check("cc_c0_rvalid", 32'(bus.c0_rvalid), 0);
        check("cc_idle_w_addr", 32'(bus.ram_w_addr), 0);
        step();

        // Read-after-write hazard on addr 7
        drive_c0(1'b1, 1'b1, 4'd7, 2'd2);
        drive_c1(1'b1, 1'b0, 4'd7, 2'd0);
        @(negedge clk);
        check("hz_c0_gnt", 32'(bus.c0_gnt), 1);
        check("hz_c1_gnt", 32'(bus.c1_gnt), 0);
        check("hz_r_en", 32'(bus.ram_r_en), 0);
        step();
        drive_c0(1'b0, 1'b0, 4'd0, 2'd0);
        @(negedge clk);
        check("hz_c1_gnt_next", 32'(bus.c1_gnt), 1);
        check("hz_c1_rvalid_early", 32'(bus.c1_rvalid), 0);
        step();
        drive_c1(1'b0, 1'b0, 4'd0, 2'd0);
        @(negedge clk);
        check("hz_c1_rvalid", 32'(bus.c1_rvalid), 1);
        check("hz_c1_rdata", 32'(bus.c1_rdata), 2);
        step();

        // Reset right after a read grant discards the read
        drive_c1(1'b1, 1'b0, 4'd3, 2'd0);
        @(negedge clk);
        check("rmr_gnt", 32'(bus.c1_gnt), 1);
        step();
        rst = 1'b1;
        drive_c0(1'b1, 1'b1, 4'd9, 2'd1);
        @(negedge clk);
        check("rmr_rvalid_in_rst", 32'(bus.c1_rvalid), 0);
        check("rmr_r_en", 32'(bus.ram_r_en), 0);
        check("rmr_w_en", 32'(bus.ram_w_en), 0);
        step();
        rst = 1'b0;
        drive_c0(1'b0, 1'b0, 4'd0, 2'd0);
        drive_c1(1'b0, 1'b0, 4'd0, 2'd0);
        @(negedge clk);
        check("rmr_rvalid_after", 32'(bus.c1_rvalid), 0);
        check("rmr_c0_rvalid_after", 32'(bus.c0_rvalid), 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bram_dual_client_arbiter.md
# bram_dual_client_arbiter

Round-robin arbiter that shares one 16-entry simple dual-port block RAM, with one write port and one registered read port, between two client requesters. Examples of clients are a button-driven writer and a periodic address scanner. Each cycle it grants at most one write and at most one read, steering each to the RAM port of matching type. It routes the one-cycle-late read data back to the client that issued the read. It sits between client logic and the RAM instance at top level and is the only driver of the RAM control ports.

## Interface
Parameters:
- ADDR_W, default 4, RAM address width (16 entries).
- DATA_W, default 2, RAM word width.

Ports:
- clk  in  1  system clock (12 MHz on board).
- rst  in  1  synchronous, active-high reset.
- c0_req, c1_req  in  1 each  client request, held until granted.
- c0_we, c1_we  in  1 each  request type: 1 = write, 0 = read.
- c0_addr, c1_addr  in  ADDR_W each  target address.
- c0_wdata, c1_wdata  in  DATA_W each  write data (ignored for reads).
- c0_gnt, c1_gnt  out  1 each  combinational grant; request consumed this cycle.
- c0_rvalid, c1_rvalid  out  1 each  registered; read data valid this cycle.
- c0_rdata, c1_rdata  out  DATA_W each  read data, equal to ram_r_data.
- ram_w_en, ram_r_en  out  1 each  RAM port enables.
- ram_w_addr, ram_r_addr  out  ADDR_W each  RAM addresses.
- ram_w_data  out  DATA_W  RAM write data.
- ram_r_data  in  DATA_W  RAM registered read output, valid the cycle after ram_r_en.

## Operation
- Clients keep req, we, addr and wdata stable from req rise until the cycle gnt=1. Req may drop the cycle after gnt or stay high to issue back-to-back operations.
- Write arbitration:
  - Exactly one client requests a write: grant it.
  - Both request writes: grant the client selected by the write pointer wptr (0 or 1), then toggle wptr.
- Read arbitration uses the same rules with its own pointer rptr.
- Pointers toggle only on contention grants. Uncontended grants leave them unchanged.
- One client writes and the other reads in the same cycle: both are granted, one per port.
  - Read-after-write hazard exception: if ram_w_en=1 and ram_r_en would target the same address, the read is withheld (gnt=0 for the reader).
  - The withheld read is granted next cycle, so it returns the newly written data.
- Granted write: ram_w_en=1, ram_w_addr/ram_w_data taken from the granted client, same cycle.
- Granted read: ram_r_en=1, ram_r_addr taken from the granted client, same cycle. A registered 1-bit tag records the client, and rd_pend=1.
- Cycle after a read grant: cN_rvalid=1 for the tagged client only, and cN_rdata=ram_r_data.
- All RAM outputs are 0 when no grant is issued on that port.

## Timing
- Reset values (after a clk edge with rst=1): wptr=0, rptr=0, tag=0, rd_pend=0, c0_rvalid=c1_rvalid=0.
- While rst=1, all gnt, ram_w_en and ram_r_en are forced to 0 combinationally. No RAM access occurs during reset.
- Reset mid-operation: a read granted in the cycle before rst rises is discarded. rvalid is 0 during and after reset until a new grant.
- Latency:
  - Grant to RAM write: 0 cycles; data in RAM at the next edge.
  - Grant to rvalid: exactly 1 cycle.
- Throughput: 1 write + 1 read per cycle, sustained.
- A client doing back-to-back reads gets rvalid every cycle.
- Under read contention each client is granted every other cycle.
- A hazard-deferred read costs exactly 1 extra cycle. Its rvalid arrives 2 cycles after the request was first presented.
- Starvation bound: a held request is granted within 2 cycles of read/write contention, or within 3 cycles when one of those cycles is a hazard deferral.
- ram_r_data is not touched when rd_pend=0. rdata outputs are don't-care when rvalid=0.

## Test plan
- **Reset:** pulse rst for 1 cycle with both clients requesting.
  - During rst: all gnt=0, ram_w_en=0, ram_r_en=0.
  - After rst: c0 is granted first on write contention (wptr=0).
- **Write contention:** c0 and c1 both write, addr 12, data 1 and 2, held for 4 cycles.
  - Grants alternate c0, c1, c0, c1.
  - A final read of addr 12 returns 2.
- **Concurrent ports:** c0 writes addr 3 = 3 while c1 reads addr 5 (preloaded 1).
  - Both gnt=1 in the same cycle.
  - The next cycle: c1_rvalid=1, c1_rdata=1, c0_rvalid=0.
- **Hazard:** c0 writes addr 7 = 2 while c1 reads addr 7 (old value 0).
  - c1_gnt=0 in that cycle and c1_gnt=1 the next.
  - c1_rvalid comes 2 cycles after the request with rdata=2.
- **Scan:** c1 reads addr 0–15 back-to-back with c0 idle.
  - 16 consecutive rvalid pulses.
  - rdata matches the init file contents in address order.
  - rptr is unchanged.
- **Reset mid-read:** read granted, rst asserted on the following edge.
  - c1_rvalid stays 0 and no RAM enables are driven during rst.
